// File: rtl/sdram_dq_pkg.sv
// Shared types for the SDRAM DQ burst sequencer: FSM states, rate-mode encoding,
// and the sizing helper for the shared beat counter.
package sdram_dq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PRE,
    ST_WR_DATA,
    ST_WR_POST,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_t;

  typedef enum logic {
    MODE_DDR = 1'b0,
    MODE_SDR = 1'b1
  } rate_mode_t;

  // Bits needed to hold a down-count that starts at max_beats-1.
  function automatic int beat_cnt_w(input int max_beats);
    return (max_beats > 2) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/sdram_dq_beat_cnt.sv
// Loadable down-counter shared by the wait and data phases; load takes effect next cycle,
// count stops at zero and tc is high while the count is zero. No backpressure.
module sdram_dq_beat_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sdram_dq_seq.sv
// Per-burst DQ pad sequencer: write preamble/data/postamble, read CAS wait and capture.
// Outputs registered except cmd_ready/wr_data_ready; optional rd_par via SDRAM_DQ_RD_PARITY_EN.
module sdram_dq_seq
  import sdram_dq_pkg::*;
#(
  parameter int W        = 32,
  parameter int CAS_LAT  = 2,
  parameter int BURST    = 4,
  parameter int FF_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_l,
  input  logic                        cmd_valid,
  input  logic                        cmd_write,
  output logic                        cmd_ready,
  input  logic                        single_rate,
  input  logic [W-1:0]                wr_data,
  input  logic                        wr_data_valid,
  output logic                        wr_data_ready,
  output logic [W-1:0]                dq_out,
  output logic                        dq_outen,
  input  logic [2*W-1:0]              dq_in,
  output logic                        upper_word_enb,
  output logic [$clog2(FF_DEPTH)-1:0] inff_sel,
  output logic [2*W-1:0]              rd_data,
  output logic                        rd_valid,
  output logic                        wr_underrun
`ifdef SDRAM_DQ_RD_PARITY_EN
  ,
  output logic [2*W/8-1:0]            rd_par
`endif
);

  localparam int CW = beat_cnt_w((BURST > CAS_LAT) ? BURST : CAS_LAT);
  localparam int SW = $clog2(FF_DEPTH);
  localparam logic [CW-1:0] CAS_LD   = CW'(CAS_LAT - 1);
  localparam logic [CW-1:0] BURST_LD = CW'(BURST - 1);
  localparam logic [CW-1:0] HALF_LD  = CW'(BURST / 2 - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(FF_DEPTH - 1);

  state_t          state, state_nxt;
  rate_mode_t      mode;
  logic            cnt_load;
  logic [CW-1:0]   cnt_val;
  logic            cnt_tc;
  logic [2*W-1:0]  rd_cap;

  sdram_dq_beat_cnt #(.CW(CW)) u_beat_cnt (
    .clk      (clk),
    .reset_l  (reset_l),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            state_nxt = ST_WR_PRE;
          end else begin
            state_nxt = ST_RD_WAIT;
            cnt_load  = 1'b1;
            cnt_val   = CAS_LD;
          end
        end
      end
      ST_WR_PRE: begin
        state_nxt = ST_WR_DATA;
        cnt_load  = 1'b1;
        cnt_val   = BURST_LD;
      end
      ST_WR_DATA: if (cnt_tc) state_nxt = ST_WR_POST;
      ST_WR_POST: state_nxt = ST_IDLE;
      ST_RD_WAIT: begin
        if (cnt_tc) begin
          state_nxt = ST_RD_DATA;
          cnt_load  = 1'b1;
          cnt_val   = (mode == MODE_SDR) ? BURST_LD : HALF_LD;
        end
      end
      ST_RD_DATA: if (cnt_tc) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready     = (state == ST_IDLE);
  // The last WR_DATA cycle only holds the final word, so it consumes nothing.
  assign wr_data_ready = (state == ST_WR_PRE) || ((state == ST_WR_DATA) && !cnt_tc);

  assign rd_cap = (mode == MODE_SDR) ? {{W{1'b0}}, dq_in[W-1:0]} : dq_in;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      mode           <= MODE_DDR;
      dq_out         <= '0;
      dq_outen       <= 1'b0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      wr_underrun    <= 1'b0;
      inff_sel       <= '0;
      upper_word_enb <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            mode <= single_rate ? MODE_SDR : MODE_DDR;
            if (cmd_write) begin
              dq_outen <= 1'b1;
              dq_out   <= '0;
            end else begin
              upper_word_enb <= !single_rate;
            end
          end
        end
        ST_WR_PRE, ST_WR_DATA: begin
          if (wr_data_ready) begin
            dq_out <= wr_data_valid ? wr_data : '0;
            if (!wr_data_valid) wr_underrun <= 1'b1;
          end
        end
        ST_WR_POST: begin
          dq_outen <= 1'b0;
          dq_out   <= '0;
        end
        ST_RD_DATA: begin
          rd_valid <= 1'b1;
          rd_data  <= rd_cap;
          inff_sel <= (inff_sel == SEL_LAST) ? '0 : inff_sel + SW'(1);
          if (cnt_tc) upper_word_enb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SDRAM_DQ_RD_PARITY_EN
  logic [2*W/8-1:0] rd_par_nxt;

  always_comb begin
    rd_par_nxt = '0;
    for (int b = 0; b < 2*W/8; b++) begin
      rd_par_nxt[b] = ^rd_cap[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      rd_par <= '0;
    end else if (state == ST_RD_DATA) begin
      rd_par <= rd_par_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_dq_seq.sv
// Randomized bench for sdram_dq_seq against a burst-timeline reference model.
module tb_sdram_dq_seq;

  localparam int W        = 32;
  localparam int CAS_LAT  = 2;
  localparam int BURST    = 4;
  localparam int FF_DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          cmd_valid, cmd_write, single_rate;
  logic          cmd_ready;
  logic [W-1:0]  wr_data;
  logic          wr_data_valid, wr_data_ready;
  logic [W-1:0]  dq_out;
  logic          dq_outen;
  logic [2*W-1:0] dq_in;
  logic          upper_word_enb;
  logic [1:0]    inff_sel;
  logic [2*W-1:0] rd_data;
  logic          rd_valid;
  logic          wr_underrun;

  int n_checks = 0;
  int n_errors = 0;
  int exp_sel = 0;
  bit exp_uflag = 1'b0;

  sdram_dq_seq #(.W(W), .CAS_LAT(CAS_LAT), .BURST(BURST), .FF_DEPTH(FF_DEPTH)) dut (
    .clk            (clk),
    .reset_l        (reset_l),
    .cmd_valid      (cmd_valid),
    .cmd_write      (cmd_write),
    .cmd_ready      (cmd_ready),
    .single_rate    (single_rate),
    .wr_data        (wr_data),
    .wr_data_valid  (wr_data_valid),
    .wr_data_ready  (wr_data_ready),
    .dq_out         (dq_out),
    .dq_outen       (dq_outen),
    .dq_in          (dq_in),
    .upper_word_enb (upper_word_enb),
    .inff_sel       (inff_sel),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .wr_underrun    (wr_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = cmd_ready;
    if (!ok) chk("idle_timeout", 64'(cmd_ready), 64'(1));
  endtask

  // ub = index of the word presented with valid low, or -1 for none.
  task automatic do_write(input logic [W-1:0] words [BURST], input int ub);
    bit ok;
    logic [W-1:0] exp_dq;
    wait_idle(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_write = 1'b1; single_rate = 1'($urandom_range(0, 1));
    wr_data_valid = 1'b0;
    for (int k = 1; k <= BURST + 3; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (ub >= 0 && k == ub + 2) exp_uflag = 1'b1;
      if (k == 1)               exp_dq = '0;
      else if (k <= BURST + 1)  exp_dq = (ub == k - 2) ? '0 : words[k-2];
      else                      exp_dq = (ub == BURST - 1) ? '0 : words[BURST-1];
      chk("wr_outen", 64'(dq_outen), 64'(k <= BURST + 2));
      chk("wr_rdy", 64'(wr_data_ready), 64'(k <= BURST));
      chk("wr_cmd_ready", 64'(cmd_ready), 64'(k == BURST + 3));
      chk("wr_underrun", 64'(wr_underrun), 64'(exp_uflag));
      chk("wr_rd_valid", 64'(rd_valid), 64'(0));
      if (k <= BURST + 2) chk("wr_dq_out", 64'(dq_out), 64'(exp_dq));
      if (k <= BURST) begin
        wr_data = words[k-1];
        wr_data_valid = (ub != k - 1);
      end else begin
        wr_data = $urandom;
        wr_data_valid = 1'b0;
      end
    end
  endtask

  task automatic do_read(input bit sdr);
    bit ok;
    int nb, ndone;
    logic [2*W-1:0] prev_dq, nxt, exp_d;
    bit exp_v;
    nb = sdr ? BURST : BURST / 2;
    wait_idle(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_write = 1'b0; single_rate = sdr;
    nxt = {$urandom, $urandom};
    dq_in = nxt; prev_dq = nxt;
    for (int k = 1; k <= CAS_LAT + nb + 1; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      exp_v = (k >= CAS_LAT + 2) && (k <= CAS_LAT + 1 + nb);
      ndone = k - (CAS_LAT + 1);
      if (ndone < 0) ndone = 0;
      if (ndone > nb) ndone = nb;
      exp_d = sdr ? {32'h0, prev_dq[W-1:0]} : prev_dq;
      chk("rd_valid", 64'(rd_valid), 64'(exp_v));
      if (exp_v) chk("rd_data", rd_data, exp_d);
      chk("rd_inff_sel", 64'(inff_sel), 64'((exp_sel + ndone) % FF_DEPTH));
      chk("rd_upper_enb", 64'(upper_word_enb), 64'(!sdr && k <= CAS_LAT + nb));
      chk("rd_outen", 64'(dq_outen), 64'(0));
      chk("rd_cmd_ready", 64'(cmd_ready), 64'(k == CAS_LAT + nb + 1));
      nxt = {$urandom, $urandom};
      dq_in = nxt; prev_dq = nxt;
    end
    exp_sel = (exp_sel + nb) % FF_DEPTH;
  endtask

  initial begin
    logic [W-1:0] wv [BURST];
    bit ok;
    reset_l = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; single_rate = 1'b0;
    wr_data = '0; wr_data_valid = 1'b0; dq_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_outen", 64'(dq_outen), 64'(0));
    chk("rst_inff_sel", 64'(inff_sel), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_underrun", 64'(wr_underrun), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_dq_out", 64'(dq_out), 64'(0));
    reset_l = 1'b1;

    wv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_write(wv, -1);
    do_read(1'b0);
    do_read(1'b1);
    do_read(1'b1);
    wv = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h01234567};
    do_write(wv, 1);
    do_read(1'b0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < BURST; i++) wv[i] = $urandom;
        do_write(wv, ($urandom_range(0, 7) < 2) ? int'($urandom_range(0, BURST - 1)) : -1);
      end else begin
        do_read(1'($urandom_range(0, 1)));
      end
    end

    // Reset landing on the first write data beat.
    wait_idle(ok);
    cmd_valid = 1'b1; cmd_write = 1'b1; single_rate = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; wr_data = 32'hCAFEF00D; wr_data_valid = 1'b1;
    @(negedge clk);
    chk("mid_outen_pre_rst", 64'(dq_outen), 64'(1));
    reset_l = 1'b0;
    @(negedge clk);
    reset_l = 1'b1; wr_data_valid = 1'b0;
    exp_sel = 0; exp_uflag = 1'b0;
    chk("mid_rst_outen", 64'(dq_outen), 64'(0));
    chk("mid_rst_ready", 64'(cmd_ready), 64'(1));
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("mid_rst_inff_sel", 64'(inff_sel), 64'(0));
    chk("mid_rst_underrun", 64'(wr_underrun), 64'(0));

    // Reset landing on the first read data beat abandons the burst.
    wait_idle(ok);
    cmd_valid = 1'b1; cmd_write = 1'b0; single_rate = 1'b0;
    repeat (CAS_LAT + 1) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    reset_l = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rd_abandon_valid", 64'(rd_valid), 64'(0));
      chk("rd_abandon_sel", 64'(inff_sel), 64'(0));
      @(negedge clk);
    end

    do_read(1'b0);
    wv = '{32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h87654321};
    do_write(wv, -1);
    do_read(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
